// File: rtl/sail_write_commit.sv
// Batches per-instruction byte writes; commits a batch byte-serially in push order once its last write arrives.
// abort discards an uncommitted batch; overflow discards it with batch_err. Optional trace: SAIL_WRITE_TRACE_EN.
module sail_write_commit #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_WIDTH-1:0]   in_paddr,
  input  logic [7:0]              in_data,
  input  logic                    in_last,
  input  logic                    abort,
  output logic                    mem_wr_valid,
  input  logic                    mem_wr_ready,
  output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
  output logic [7:0]              mem_wr_data,
  output logic                    commit_done,
  output logic                    batch_err,
  output logic [$clog2(DEPTH):0]  pending
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            push, pop, full, store, flush;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [7:0]            data_mem [DEPTH];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      addr_mem[wr_ptr_q] <= in_paddr;
      data_mem[wr_ptr_q] <= in_data;
    end
  end

  // Output logic
  always_comb begin
    in_ready     = (state_q != DRAIN);
    mem_wr_valid = (state_q == DRAIN) && (cnt_q != '0);
    mem_wr_addr  = addr_mem[rd_ptr_q];
    mem_wr_data  = data_mem[rd_ptr_q];
    commit_done  = done_q;
    batch_err    = err_q;
    pending      = cnt_q;
  end

  assign push = in_valid && in_ready;
  assign pop  = mem_wr_valid && mem_wr_ready;
  assign full = (cnt_q == CW'(DEPTH));

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    store    = 1'b0;
    flush    = 1'b0;
    case (state_q)
      IDLE: begin
        if (push) begin
          store   = 1'b1;
          state_d = in_last ? DRAIN : COLLECT;
        end
      end
      COLLECT: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else if (push) begin
          store = !full;
          if (in_last) begin
            // A dropped final byte still closes the batch.
            if (ovf_q || full) begin
              flush   = 1'b1;
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = DRAIN;
            end
          end else begin
            ovf_d = ovf_q || full;
          end
        end
      end
      DRAIN: begin
        if (pop) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (store) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      cnt_d    = cnt_q + CW'(1);
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      store    = 1'b0;
    end
  end

`ifdef SAIL_WRITE_TRACE_EN
  integer trace_cnt;
  always @(posedge clk) begin
    if (reset) begin
      trace_cnt = 0;
    end else begin
      if (pop) begin
        $display("[sail_write_commit] mem[0x%016h] <- 0x%02h", mem_wr_addr, mem_wr_data);
        trace_cnt = trace_cnt + 1;
      end
      if (done_q) begin
        $display("[sail_write_commit] commit_done: %0d bytes", trace_cnt);
        trace_cnt = 0;
      end
    end
  end
`endif

endmodule

// File: doc/sail_write_commit.md
Name: sail_write_commit

Overview:
- Downstream consumer of the emulator memory-write stage.
- Takes the per-instruction stream of byte writes ({paddr, data}, the same records carried in the write queue) and buffers each instruction's writes as one batch.
- A batch commits to the backing memory port only once the instruction's final write is seen. An aborted instruction (exception) discards its whole batch.
- Commit is byte-serial, in program order, over a valid/ready memory port.

Parameters:
- DEPTH, 16: maximum bytes per batch; power of two, at least 2.
- ADDR_WIDTH, 64: physical address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  a byte-write record is offered.
- in_ready  output  1  the block can accept a record.
- in_paddr  input  ADDR_WIDTH  byte physical address.
- in_data  input  8  byte value.
- in_last  input  1  this record is the final write of the instruction.
- abort  input  1  discard the uncommitted batch.
- mem_wr_valid  output  1  a commit write is presented.
- mem_wr_ready  input  1  memory accepts the write.
- mem_wr_addr  output  ADDR_WIDTH  commit address.
- mem_wr_data  output  8  commit data.
- commit_done  output  1  one-cycle pulse: batch fully written.
- batch_err  output  1  one-cycle pulse: batch discarded due to overflow.
- pending  output  $clog2(DEPTH)+1  bytes currently buffered.

Behaviour:
- The buffer is a circular FIFO of DEPTH entries {paddr, data}, with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, and an occupancy count (pending) of $clog2(DEPTH)+1 bits.
- States are IDLE, COLLECT and DRAIN.
- Reset: state IDLE; pointers 0; pending 0; overflow flag 0; mem_wr_valid 0; commit_done 0; batch_err 0. Reset mid-DRAIN drops all remaining entries, and nothing further is written.
- in_ready is 1 in IDLE and COLLECT, and 0 in DRAIN.
- A push occurs when in_valid && in_ready.
- IDLE:
  - A push without in_last writes the entry and moves to COLLECT.
  - A push with in_last writes the entry and moves to DRAIN.
  - abort is ignored in IDLE.
- COLLECT:
  - A push when pending < DEPTH stores the entry.
  - A push when pending == DEPTH drops the byte and sets the sticky overflow flag.
  - A push with in_last (stored or dropped) ends the batch:
    - if overflow is set (including a flag set by this same push), flush the FIFO, clear overflow, pulse batch_err next cycle, go to IDLE;
    - otherwise go to DRAIN.
  - abort in COLLECT: flush (pointers and pending to 0), clear overflow, go to IDLE. No commit_done or batch_err pulse.
  - abort and a push in the same cycle: abort wins and the byte is dropped.
- DRAIN:
  - mem_wr_valid = (pending != 0). mem_wr_addr and mem_wr_data come combinationally from the head entry and stay stable while valid && !ready.
  - A handshake (mem_wr_valid && mem_wr_ready) pops one entry; at most one write per cycle.
  - On the handshake that empties the FIFO: go to IDLE and pulse commit_done in the following cycle.
  - abort is ignored in DRAIN, because a committed batch is architecturally visible.
- Latency:
  - When in_last is accepted in cycle N, the first mem_wr_valid is seen in cycle N+1.
  - An N-byte batch with mem_wr_ready held at 1 finishes its final handshake in cycle N+N and shows commit_done in cycle N+N+1.
  - A new batch can be accepted in the cycle commit_done is high.
- Ordering: writes commit in push order. Duplicate addresses are not merged, so the last write wins at memory.
- pending updates every cycle by +push −pop; push and pop are never simultaneous.

Optional Feature:
- Macro: SAIL_WRITE_TRACE_EN.
- When defined, every commit handshake executes a $display line formatted "[sail_write_commit] mem[0x%016h] <- 0x%02h", and commit_done prints the batch byte count. The count is held in a simulation-only integer.
- When not defined, there is no $display, no extra state, and cycle behaviour is identical.

Test Plan:
- Push 4 bytes at 0x1000..0x1003 with data 0xA0..0xA3, last on the 4th, mem_wr_ready=1: four writes 0x1000/A0 … 0x1003/A3 in consecutive cycles, then commit_done 1 cycle; pending is 4 before draining and returns to 0.
- Push 3 bytes, then assert abort with in_valid in the same cycle: no mem_wr_valid ever, pending=0, state IDLE, in_ready=1 the next cycle.
- Push DEPTH+1=17 bytes, last on the 17th: batch_err pulses once, zero memory writes, pending=0.
- 2-byte batch with mem_wr_ready low for 3 cycles: addr/data hold at the first entry; in_ready=0 throughout DRAIN; abort during the stall is ignored and both bytes still commit.
- Single byte with in_last in IDLE (0x2000/0x5A), then a fresh batch in the commit_done cycle: write 0x2000/5A, and the new batch's first byte is accepted that same cycle.
- Assert reset for 1 cycle mid-DRAIN with 5 bytes pending: all outputs return to reset values the next cycle and no further writes occur.
